// File: rtl/cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cfg_pkg
// Brief    : Shared PWM/output configuration register map and widths.
// Revision : 1.0 - initial release
// ============================================================================
package cfg_pkg;

  localparam int CFG_DATA_W   = 8;
  localparam int CFG_NUM_REGS = 5;

  typedef enum logic [2:0] {
    CFG_EN_OUT_LO = 3'd0,
    CFG_EN_OUT_HI = 3'd1,
    CFG_EN_PWM_LO = 3'd2,
    CFG_EN_PWM_HI = 3'd3,
    CFG_PWM_DUTY  = 3'd4
  } cfg_addr_e;

endpackage : cfg_pkg
`default_nettype wire

// File: rtl/cfg_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : cfg_write_arbiter_if
// Brief    : Multi-requester write bus (valid/ready, address, data, error).
// Revision : 1.0 - initial release
// ============================================================================
interface cfg_write_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_err;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, req_err
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, req_err
  );

endinterface : cfg_write_arbiter_if
`default_nettype wire

// File: rtl/cfg_write_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin search starting at the supplied pointer.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  logic [IDX_W:0] w_cand;

  // One extra bit on the candidate lets the modulo wrap be a single subtract.
  always_comb begin
    gnt_o  = '0;
    idx_o  = '0;
    any_o  = 1'b0;
    w_cand = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = {1'b0, ptr_i} + (IDX_W+1)'(k);
      if (w_cand >= (IDX_W+1)'(NUM_REQ)) begin
        w_cand = w_cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!any_o && req_i[w_cand[IDX_W-1:0]]) begin
        any_o                       = 1'b1;
        idx_o                       = w_cand[IDX_W-1:0];
        gnt_o[w_cand[IDX_W-1:0]]    = 1'b1;
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/cfg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cfg_write_arbiter
// Brief    : Five-register config bank with a round-robin shared write port.
// Revision : 1.0 - initial release
// ============================================================================
module cfg_write_arbiter
  import cfg_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cfg_write_arbiter_if.slave    req_if,
  output logic [DATA_W-1:0]     en_reg_out_7_0,
  output logic [DATA_W-1:0]     en_reg_out_15_8,
  output logic [DATA_W-1:0]     en_reg_pwm_7_0,
  output logic [DATA_W-1:0]     en_reg_pwm_15_8,
  output logic [DATA_W-1:0]     pwm_duty_cycle,
  output logic                  cfg_update,
  output logic [2:0]            cfg_update_addr
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]   rr_ptr_q;
  logic [IDX_W-1:0]   rr_ptr_d;
  logic [NUM_REQ-1:0] w_gnt;
  logic [IDX_W-1:0]   w_idx;
  logic               w_any;
  logic [ADDR_W-1:0]  w_addr;
  logic [DATA_W-1:0]  w_data;
  logic               w_in_range;
  logic               w_wr_en;

  logic [DATA_W-1:0]  cfg_q [CFG_NUM_REGS];
  logic               cfg_update_q;
  logic [2:0]         cfg_update_addr_q;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req_i (req_if.req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (w_gnt),
    .idx_o (w_idx),
    .any_o (w_any)
  );

  assign w_addr     = req_if.req_addr[w_idx*ADDR_W +: ADDR_W];
  assign w_data     = req_if.req_data[w_idx*DATA_W +: DATA_W];
  // Full-width compare so aliases such as 0x08 are rejected, not folded to 0.
  assign w_in_range = (w_addr < ADDR_W'(CFG_NUM_REGS));
  assign w_wr_en    = w_any & rst_n & w_in_range;

  assign req_if.req_ready = w_gnt & {NUM_REQ{rst_n}};
  assign req_if.req_err   = req_if.req_ready & {NUM_REQ{~w_in_range}};

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (w_any) begin
      rr_ptr_d = (w_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q          <= '0;
      cfg_update_q      <= 1'b0;
      cfg_update_addr_q <= 3'd0;
      for (int r = 0; r < CFG_NUM_REGS; r++) begin
        cfg_q[r] <= '0;
      end
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      cfg_update_q <= w_wr_en;
      if (w_wr_en) begin
        cfg_update_addr_q <= w_addr[2:0];
      end
      for (int r = 0; r < CFG_NUM_REGS; r++) begin
        if (w_wr_en && (w_addr[2:0] == 3'(r))) begin
          cfg_q[r] <= w_data;
        end
      end
    end
  end

  assign en_reg_out_7_0  = cfg_q[int'(CFG_EN_OUT_LO)];
  assign en_reg_out_15_8 = cfg_q[int'(CFG_EN_OUT_HI)];
  assign en_reg_pwm_7_0  = cfg_q[int'(CFG_EN_PWM_LO)];
  assign en_reg_pwm_15_8 = cfg_q[int'(CFG_EN_PWM_HI)];
  assign pwm_duty_cycle  = cfg_q[int'(CFG_PWM_DUTY)];
  assign cfg_update      = cfg_update_q;
  assign cfg_update_addr = cfg_update_addr_q;

endmodule : cfg_write_arbiter
`default_nettype wire
